// File: rtl/sd_req_arbiter.sv
// rtl/sd_req_arbiter.sv - round-robin arbiter sharing the hps_io block channel between disk requesters
module sd_req_arbiter #(
    parameter int NDRV    = 4,
    parameter int TIMEOUT = 50_000_000
) (
    input  logic                clk_sys,
    input  logic                rstn,
    input  logic [NDRV-1:0]     req_rd,
    input  logic [NDRV-1:0]     req_wr,
    input  logic [32*NDRV-1:0]  req_lba,
    output logic [NDRV-1:0]     req_done,
    output logic [NDRV-1:0]     req_err,
    output logic [NDRV-1:0]     drv_active,
    output logic [NDRV-1:0]     drv_buff_wr,
    output logic                busy,
    output logic [31:0]         sd_lba,
    output logic [NDRV-1:0]     sd_rd,
    output logic [NDRV-1:0]     sd_wr,
    input  logic [NDRV-1:0]     sd_ack,
    input  logic                sd_buff_wr
);
    localparam int PW = $clog2(NDRV);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_XFER, S_DONE} state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   ptr, ptr_nxt, g, win, sel;
    logic [NDRV-1:0] req_any, win_oh, g_oh;
    logic [31:0]     win_lba;
    logic [CW-1:0]   cnt;
    logic            found, ack_g, timed_out;
    int              idx;

    assign req_any   = req_rd | req_wr;
    assign ack_g     = sd_ack[g];
    assign timed_out = (cnt == CNT_LAST);
    assign win_oh    = NDRV'(1) << win;
    assign g_oh      = NDRV'(1) << g;
    assign ptr_nxt   = (win == PW'(NDRV - 1)) ? '0 : win + 1'b1;
    assign win_lba   = req_lba[{win, 5'b0} +: 32];

    // Search starts at ptr and wraps; the first requester with either direction pending wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        sel   = '0;
        idx   = 0;
        for (int k = 0; k < NDRV; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NDRV) idx = idx - NDRV;
            sel = PW'(idx);
            if (!found && req_any[sel]) begin
                found = 1'b1;
                win   = sel;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (found) state_nxt = S_ISSUE;
            S_ISSUE: begin
                if (ack_g)          state_nxt = S_XFER;
                else if (timed_out) state_nxt = S_IDLE;
            end
            S_XFER:  if (!ack_g) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        drv_buff_wr = '0;
        if (state == S_XFER && sd_buff_wr) drv_buff_wr = drv_active;
    end

    always_ff @(posedge clk_sys or negedge rstn) begin
        if (!rstn) begin
            state      <= S_IDLE;
            ptr        <= '0;
            g          <= '0;
            cnt        <= '0;
            sd_lba     <= '0;
            sd_rd      <= '0;
            sd_wr      <= '0;
            req_done   <= '0;
            req_err    <= '0;
            drv_active <= '0;
            busy       <= 1'b0;
        end else begin
            state    <= state_nxt;
            busy     <= (state_nxt != S_IDLE);
            req_done <= '0;
            req_err  <= '0;
            case (state)
                S_IDLE: begin
                    // A pending write on the winner goes first; its read stays pending.
                    if (found) begin
                        g          <= win;
                        ptr        <= ptr_nxt;
                        sd_lba     <= win_lba;
                        drv_active <= win_oh;
                        cnt        <= '0;
                        if (req_wr[win]) sd_wr <= win_oh;
                        else             sd_rd <= win_oh;
                    end
                end
                S_ISSUE: begin
                    if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
                    if (ack_g || timed_out) begin
                        sd_rd <= '0;
                        sd_wr <= '0;
                    end
                    if (!ack_g && timed_out) begin
                        req_err    <= g_oh;
                        drv_active <= '0;
                    end
                end
                S_XFER:  if (!ack_g) req_done <= g_oh;
                S_DONE:  drv_active <= '0;
                default: ;
            endcase
        end
    end
endmodule

// File: doc/sd_req_arbiter.md
# sd_req_arbiter

Shares the single HPS virtual-disk block channel between up to NDRV block requesters (FDD0, FDD1, HDD, spare). Each requester holds a level read or write request with its LBA. The block picks one by round-robin, drives `sd_lba`/`sd_rd`/`sd_wr` toward `hps_io` and follows the `sd_ack` handshake to completion. It steers buffer writes to the granted requester, then returns a one-cycle done or error pulse. It sits in the emu top between `hps_io` and the PC88 disk controllers.

## Interface

Parameters:
- NDRV, 4 — number of requesters, 2..4
- TIMEOUT, 50_000_000 — cycles to wait for ack rise before abandoning a request (1 s at clk_sys)

Ports:
- clk_sys  in  1  system clock. One clock, no other clock domains.
- rstn  in  1  asynchronous, active-low reset
- req_rd  in  NDRV  level read request per requester
- req_wr  in  NDRV  level write request per requester
- req_lba  in  32*NDRV  LBA per requester; requester i uses bits [32i+31:32i]
- req_done  out  NDRV  one-cycle pulse, transaction finished
- req_err  out  NDRV  one-cycle pulse, transaction abandoned on timeout
- drv_active  out  NDRV  one-hot grant, held from ISSUE through DONE
- drv_buff_wr  out  NDRV  sd_buff_wr steered to the granted requester
- busy  out  1  FSM not in IDLE
- sd_lba  out  32  LBA toward hps_io
- sd_rd  out  NDRV  read strobe toward hps_io
- sd_wr  out  NDRV  write strobe toward hps_io
- sd_ack  in  NDRV  ack from hps_io
- sd_buff_wr  in  1  buffer write strobe from hps_io

## Operation

- Reset values: sd_rd=0, sd_wr=0, sd_lba=0, req_done=0, req_err=0, drv_active=0, busy=0, state=IDLE, rr pointer=0, timeout counter=0.
- Requests are levels. A requester holds a request until it sees its req_done or req_err.
- A request dropped before grant is ignored.
- A request dropped after grant does not cancel the transaction. It completes and still pulses done or err.
- Round-robin grant:
  - Search starts at index ptr and wraps modulo NDRV.
  - The first index with req_rd|req_wr set wins.
  - On grant, ptr ← winner+1 (wraps to 0 after NDRV-1).
- If req_rd and req_wr are both set on the winner, the write is serviced first. The read remains pending.
- States:
  - IDLE: busy=0. If any request is pending: latch g=winner, dir, and sd_lba←req_lba[g]; set drv_active[g]; clear the counter; go to ISSUE.
  - ISSUE: sd_rd[g] (read) or sd_wr[g] (write) is held at 1 and the counter increments.
    - If sd_ack[g]=1: drop the strobe and go to XFER.
    - Else if counter == TIMEOUT-1: drop the strobe, pulse req_err[g], go to IDLE.
  - XFER: strobes are 0. When sd_ack[g]=0, go to DONE.
  - DONE: pulse req_done[g] for one cycle, clear drv_active, go to IDLE.
- sd_ack bits other than g are ignored in every state.
- drv_buff_wr[i] = sd_buff_wr & drv_active[i] & (state==XFER). This is combinational; all other outputs are registered.
- sd_lba holds its last value after a transaction and changes only on grant.
- Counter width is $clog2(TIMEOUT+1). It saturates and never wraps.

## Timing

- Request seen in IDLE at cycle N gives strobe high and sd_lba valid at N+1.
- sd_ack[g] sampled high at cycle M gives strobe low at M+1, in XFER.
- sd_ack[g] sampled low in XFER at cycle K gives req_done[g] high at K+1 for exactly one cycle. IDLE is at K+2.
- Minimum spacing between consecutive grants is one IDLE cycle.
- An ack rising and falling within the same ISSUE cycle window is not possible by the hps_io protocol; the bench need not cover it.
- On timeout, req_err rises the cycle after the counter reaches TIMEOUT-1. The strobe is low in the same cycle as req_err.
- Reset mid-transaction (rstn low): all outputs are forced to reset values immediately and asynchronously. After release, the FSM starts in IDLE. Pending requests are re-arbitrated from ptr=0.

## Test plan

- Single read: req_rd[0]=1 with req_lba0=0x00000123. Expect sd_lba=0x123 and sd_rd=4'b0001 next cycle. Ack high 3 cycles later drops sd_rd; 2 sd_buff_wr pulses appear only on drv_buff_wr[0]; ack low gives a one-cycle req_done[0].
- Round-robin: req_rd[0] and req_rd[2] held after reset, each completed by a bench ack model. Expect grant order 0, 2, 0, 2. A third request on drive 1 arriving during a drive-0 transfer is served next, before drive 2.
- Write priority: req_rd[1]=req_wr[1]=1. Expect sd_wr=4'b0010 first. After req_done[1] with req_wr dropped, sd_rd=4'b0010 follows.
- Timeout: TIMEOUT=16, req_wr[3]=1, no ack. Expect sd_wr[3] high exactly 16 cycles, then req_err[3] pulse, busy=0, and no req_done.
- Wrong-drive ack and late drop: drive 0 granted, sd_ack[1] pulsed, then req_rd[0] dropped. Expect the FSM to stay in ISSUE until sd_ack[0]; req_done[0] still pulses.
- Reset mid-XFER: rstn low for 1 cycle while sd_ack[2]=1. Expect sd_rd=0, drv_active=0, busy=0 immediately. After release with req_rd[2] still high, a new grant to drive 2 occurs once sd_ack is low and IDLE is entered.
